// File: rtl/trig_line_pkg.sv
// ============================================================================
// trig_line_pkg : shared codes, source indices and FSM encoding for trig_line_sched
// Rev 1.0
// ============================================================================
`default_nettype none

package trig_line_pkg;

    localparam logic [3:0] CODE_ALIGN = 4'b1010;
    localparam logic [3:0] CODE_DELTA = 4'b1001;
    localparam logic [3:0] CODE_PED   = 4'b1100;

    localparam int SRC_ALIGN = 0;
    localparam int SRC_DELTA = 1;
    localparam int SRC_PHYS  = 2;
    localparam int SRC_PED   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/trig_line_sched_prio_arb.sv
// ============================================================================
// prio_arb : combinational fixed-priority one-hot picker, bit 0 wins
// Rev 1.0
// ============================================================================
`default_nettype none

module prio_arb
    import trig_line_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] cand,
    output logic [N-1:0] pick
);

    // Two's-complement trick isolates the lowest set bit.
    assign pick = cand & (~cand + N'(1));

endmodule

`default_nettype wire

// File: rtl/trig_line_sched.sv
// ============================================================================
// trig_line_sched : arbitrates trigger requesters and serializes codes onto out_adc
// Rev 1.0
// ============================================================================
`default_nettype none

module trig_line_sched
    import trig_line_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CODE_W  = 4,
    parameter int MIN_GAP = 4,
    parameter int DROP_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_live,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*CODE_W-1:0] req_code,
    input  logic [N_REQ-1:0]        en_mask,
    output logic                    out_adc,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic [31:0]             sent_cnt
);

    localparam int BIT_W  = cnt_width(CODE_W - 1);
    localparam int GAP_W  = cnt_width(MIN_GAP);
    localparam bit NO_GAP = (MIN_GAP == 0);

    state_t            state, state_nxt;
    logic [N_REQ-1:0]  pending, pending_nxt;
    logic [CODE_W-1:0] code_q     [N_REQ];
    logic [CODE_W-1:0] code_q_nxt [N_REQ];
    logic [CODE_W-1:0] shift_reg, shift_nxt, code_sel;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic              out_nxt, busy_nxt;
    logic [N_REQ-1:0]  grant_nxt;
    logic [DROP_W-1:0] drop_nxt;
    logic [31:0]       sent_nxt;
    logic [N_REQ-1:0]  eff_req, cand, pick, take;
    logic              decide;

    assign eff_req = req & en_mask;
    assign cand    = pending | eff_req;

    // A new code may launch from IDLE, on the last GAP edge, or straight after
    // the LSB when no gap is configured.
    assign decide = (state == IDLE)
                 || (NO_GAP && (state == SHIFT) && (bit_cnt == '0))
                 || ((state == GAP) && (gap_cnt == GAP_W'(1)));
    assign take   = decide ? pick : '0;

    prio_arb #(.N(N_REQ)) u_arb (
        .cand (cand),
        .pick (pick)
    );

    // A source granted in the cycle of its own pulse uses the live code.
    always_comb begin
        code_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (take[i]) begin
                code_sel = pending[i] ? code_q[i] : req_code[i*CODE_W +: CODE_W];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        code_q_nxt  = code_q;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        out_nxt     = out_adc;
        grant_nxt   = '0;
        drop_nxt    = drop_cnt;
        sent_nxt    = sent_cnt;

        for (int i = 0; i < N_REQ; i++) begin
            if (take[i]) begin
                // A pulse arriving as the stored request is granted re-arms the source.
                pending_nxt[i] = pending[i] & eff_req[i];
                if (pending[i] && eff_req[i]) begin
                    code_q_nxt[i] = req_code[i*CODE_W +: CODE_W];
                end
            end else if (eff_req[i]) begin
                if (pending[i]) begin
                    if (drop_nxt != '1) begin
                        drop_nxt = drop_nxt + DROP_W'(1);
                    end
                end else begin
                    pending_nxt[i] = 1'b1;
                    code_q_nxt[i]  = req_code[i*CODE_W +: CODE_W];
                end
            end
        end

        case (state)
            IDLE: begin
                out_nxt = 1'b0;
            end
            SHIFT: begin
                if (bit_cnt != '0) begin
                    shift_nxt   = shift_reg << 1;
                    out_nxt     = shift_nxt[CODE_W-1];
                    bit_cnt_nxt = bit_cnt - BIT_W'(1);
                end else begin
                    out_nxt  = 1'b0;
                    sent_nxt = sent_cnt + 32'd1;
                    if (NO_GAP) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_W'(MIN_GAP);
                    end
                end
            end
            GAP: begin
                out_nxt = 1'b0;
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                out_nxt   = 1'b0;
            end
        endcase

        if (|take) begin
            state_nxt   = SHIFT;
            shift_nxt   = code_sel;
            out_nxt     = code_sel[CODE_W-1];
            bit_cnt_nxt = BIT_W'(CODE_W - 1);
            grant_nxt   = take;
        end

        // Dropping the live gate flushes everything, counters included.
        if (!in_live) begin
            state_nxt   = IDLE;
            pending_nxt = '0;
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
            gap_cnt_nxt = '0;
            out_nxt     = 1'b0;
            grant_nxt   = '0;
            drop_nxt    = '0;
            sent_nxt    = '0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            code_q    <= '{default: '0};
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            out_adc   <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            drop_cnt  <= '0;
            sent_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            code_q    <= code_q_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            out_adc   <= out_nxt;
            grant     <= grant_nxt;
            busy      <= busy_nxt;
            drop_cnt  <= drop_nxt;
            sent_cnt  <= sent_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trig_line_sched.sv
// ============================================================================
// tb_trig_line_sched : table vectors, corner sequences and a timestamp-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_trig_line_sched;
    import trig_line_pkg::*;

    localparam int CW  = 4;
    localparam int GAP = 4;

    logic        clk;
    logic        rst_n;
    logic        in_live;
    logic [3:0]  req;
    logic [15:0] req_code;
    logic [3:0]  en_mask;

    logic        out_adc, busy;
    logic [3:0]  grant;
    logic [15:0] drop_cnt;
    logic [31:0] sent_cnt;

    logic        out0, busy0;
    logic [3:0]  grant0;
    logic [15:0] drop0;
    logic [31:0] sent0;

    int ntests = 0;
    int nfail  = 0;
    bit mchk   = 0;

    trig_line_sched #(.N_REQ(4), .CODE_W(CW), .MIN_GAP(GAP), .DROP_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_live(in_live), .req(req), .req_code(req_code),
        .en_mask(en_mask), .out_adc(out_adc), .grant(grant), .busy(busy),
        .drop_cnt(drop_cnt), .sent_cnt(sent_cnt)
    );

    trig_line_sched #(.N_REQ(4), .CODE_W(CW), .MIN_GAP(0), .DROP_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_live(in_live), .req(req), .req_code(req_code),
        .en_mask(en_mask), .out_adc(out0), .grant(grant0), .busy(busy0),
        .drop_cnt(drop0), .sent_cnt(sent0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: code occupancy by cycle timestamps ----
    int unsigned m_now = 0;
    int unsigned m_start;
    bit          m_act;
    logic [3:0]  m_cur;
    logic [3:0]  m_pend;
    logic [3:0]  m_pcode [4];
    logic        m_out, m_busy;
    logic [3:0]  m_grant;
    logic [15:0] m_drop;
    logic [31:0] m_sent;

    task automatic m_reset();
        m_act = 0; m_pend = '0; m_out = 0; m_busy = 0; m_grant = '0;
        m_drop = '0; m_sent = '0; m_cur = '0;
    endtask

    task automatic m_step();
        int unsigned n;
        logic [3:0]  eff, cand;
        logic [3:0]  slice [4];
        int          g;
        n = m_now + 1;
        m_now = n;
        if (!in_live) begin
            m_reset();
            return;
        end
        for (int i = 0; i < 4; i++) slice[i] = req_code[i*4 +: 4];
        eff = req & en_mask;
        if (m_act && n == m_start + CW) m_sent = m_sent + 1;
        if (m_act && n >= m_start + CW + GAP) m_act = 0;
        cand = m_pend | eff;
        g = -1;
        if (!m_act) begin
            for (int i = 3; i >= 0; i--) if (cand[i]) g = i;
        end
        m_grant = '0;
        if (g >= 0) begin
            m_act = 1;
            m_start = n;
            m_cur = m_pend[g] ? m_pcode[g] : slice[g];
            m_grant[g] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (i == g) begin
                if (m_pend[i] && eff[i]) m_pcode[i] = slice[i];
                m_pend[i] = m_pend[i] & eff[i];
            end else if (eff[i]) begin
                if (m_pend[i]) begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
                end else begin
                    m_pend[i] = 1'b1;
                    m_pcode[i] = slice[i];
                end
            end
        end
        m_busy = m_act;
        m_out = (m_act && (n - m_start) < CW) ? m_cur[CW - 1 - int'(n - m_start)] : 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    always @(negedge clk) begin
        if (mchk && rst_n) begin
            ntests++;
            if (out_adc !== m_out || grant !== m_grant || busy !== m_busy ||
                drop_cnt !== m_drop || sent_cnt !== m_sent) begin
                nfail++;
                $display("FAIL model t=%0t out %b/%b grant %b/%b busy %b/%b drop %0d/%0d sent %0d/%0d (got/exp)",
                         $time, out_adc, m_out, grant, m_grant, busy, m_busy,
                         drop_cnt, m_drop, sent_cnt, m_sent);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] en;
        logic       out;
        logic [3:0] grant;
        logic       busy;
        int         sent;
        int         drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] r, input logic [3:0] e, input logic o,
                               input logic [3:0] g, input logic b, input int s, input int d);
        vec_t x;
        x.req = r; x.en = e; x.out = o; x.grant = g; x.busy = b; x.sent = s; x.drop = d;
        return x;
    endfunction

    int live_hold;

    initial begin
        m_reset();
        rst_n = 0; in_live = 1; req = '0; en_mask = 4'hF;
        req_code = {CODE_PED, 4'b1001, 4'b0110, CODE_ALIGN};

        // Align code then gap, priority pair, drop, masked source
        tbl.push_back(v(4'b0001, 4'hF, 1, 4'b0001, 1, 0, 0));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 4'hF, 1, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 0, 0));
        repeat (4) tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 1, 0));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 0, 1, 0));
        tbl.push_back(v(4'b0101, 4'hF, 1, 4'b0001, 1, 1, 0));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 1, 0));
        tbl.push_back(v(4'b0000, 4'hF, 1, 4'b0000, 1, 1, 0));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 1, 0));
        repeat (4) tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 2, 0));
        tbl.push_back(v(4'b0000, 4'hF, 1, 4'b0100, 1, 2, 0));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 2, 0));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 2, 0));
        tbl.push_back(v(4'b0000, 4'hF, 1, 4'b0000, 1, 2, 0));
        repeat (4) tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 3, 0));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 0, 3, 0));
        tbl.push_back(v(4'b0001, 4'hF, 1, 4'b0001, 1, 3, 0));
        tbl.push_back(v(4'b0010, 4'hF, 0, 4'b0000, 1, 3, 0));
        tbl.push_back(v(4'b0000, 4'hF, 1, 4'b0000, 1, 3, 0));
        tbl.push_back(v(4'b0010, 4'hF, 0, 4'b0000, 1, 3, 1));
        repeat (4) tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 4, 1));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0010, 1, 4, 1));
        tbl.push_back(v(4'b0000, 4'hF, 1, 4'b0000, 1, 4, 1));
        tbl.push_back(v(4'b0000, 4'hF, 1, 4'b0000, 1, 4, 1));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 4, 1));
        repeat (4) tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 1, 5, 1));
        tbl.push_back(v(4'b1000, 4'h7, 0, 4'b0000, 0, 5, 1));
        tbl.push_back(v(4'b0000, 4'h7, 0, 4'b0000, 0, 5, 1));
        tbl.push_back(v(4'b0000, 4'hF, 0, 4'b0000, 0, 5, 1));

        repeat (3) @(negedge clk);
        chk("reset.out", out_adc, 0);
        chk("reset.grant", grant, 0);
        chk("reset.busy", busy, 0);
        chk("reset.drop", drop_cnt, 0);
        chk("reset.sent", sent_cnt, 0);
        rst_n = 1;
        mchk = 1;

        foreach (tbl[k]) begin
            req = tbl[k].req;
            en_mask = tbl[k].en;
            step();
            chk($sformatf("tbl%0d.out", k), out_adc, tbl[k].out);
            chk($sformatf("tbl%0d.grant", k), grant, tbl[k].grant);
            chk($sformatf("tbl%0d.busy", k), busy, tbl[k].busy);
            chk($sformatf("tbl%0d.sent", k), sent_cnt, tbl[k].sent);
            chk($sformatf("tbl%0d.drop", k), drop_cnt, tbl[k].drop);
        end
        req = '0; en_mask = 4'hF;

        // Live gate drops while the second bit is on the line
        req = 4'b0001; step();
        req = 4'b0010; step();
        chk("live.bit2", out_adc, 0);
        req = 4'b0000; in_live = 0; step();
        chk("live.out", out_adc, 0);
        chk("live.busy", busy, 0);
        chk("live.sent", sent_cnt, 0);
        chk("live.drop", drop_cnt, 0);
        in_live = 1; step();
        chk("live.nopend", {grant, busy}, 5'b0);
        req = 4'b0001; step();
        chk("live.restart_out", out_adc, 1);
        chk("live.restart_grant", grant, 4'b0001);
        req = 4'b0000;
        repeat (8) step();
        chk("live.after_sent", sent_cnt, 1);
        chk("live.after_busy", busy, 0);

        // Asynchronous reset in the middle of the gap with source 1 pending
        req = 4'b0001; step();
        req = 4'b0010; step();
        req = 4'b0000;
        repeat (4) step();
        chk("arst.pre_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("arst.out", out_adc, 0);
        chk("arst.grant", grant, 0);
        chk("arst.busy", busy, 0);
        chk("arst.sent", sent_cnt, 0);
        chk("arst.drop", drop_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("arst.quiet%0d", k), {out_adc, grant}, 5'b0);
        end

        // Back-to-back codes with no gap on the second instance
        begin
            logic [7:0] exp_bits;
            exp_bits = {CODE_ALIGN, 4'b0110};
            req = 4'b0011; step();
            req = 4'b0000;
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("gap0.bit%0d", k), {out0, busy0}, {exp_bits[7-k], 1'b1});
                if (k == 0) chk("gap0.grant0", grant0, 4'b0001);
                if (k == 4) chk("gap0.grant1", grant0, 4'b0010);
                step();
            end
            chk("gap0.idle", busy0, 0);
            chk("gap0.sent", sent0, 2);
        end
        repeat (12) step();

        // Randomized traffic against the model
        live_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (live_hold > 0) begin
                live_hold--;
                in_live = 0;
            end else if ($urandom_range(99) == 0) begin
                in_live = 0;
                live_hold = $urandom_range(2);
            end else begin
                in_live = 1;
            end
            for (int i = 0; i < 4; i++) req[i] = ($urandom_range(5) == 0);
            if ($urandom_range(49) == 0) en_mask = 4'($urandom_range(15));
            req_code = 16'($urandom);
            step();
        end
        req = '0; in_live = 1; en_mask = 4'hF;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
